fft_stage4_seq: RTL
===================

# fft_stage4_seq

- Fourth radix-2 DIT stage of the 32-point FFT. It sits directly downstream of stage 3 and consumes stage 3's 32 complex outputs.
- It computes the 16 stage-4 butterflies (span 8, twiddles W^0, W^2 … W^14) serially on one shared complex butterfly, over a 2-deep pipeline.
- Results are held in an output register bank.
- It uses the same start/finish handshake as the other stages.

## Interface
Parameters:
- DATA_WIDTH, 8, total signed fixed-point width
- INTEGER, 4, integer bits including sign
- FRACTION, 4, fraction bits (INTEGER+FRACTION = DATA_WIDTH)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state while low
- stage4_start  input  1  one-cycle start pulse
- stage4_Finish  output  1  one-cycle completion pulse
- stage4_busy  output  1  high while a transform is in progress
- Stage3_out_real, Stage3_out_imag  input  32*DATA_WIDTH each  element n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- Twiddle_real, Twiddle_imag  input  8*DATA_WIDTH each  slot k holds W^(2k), k=0..7
- Stage4_out_real, Stage4_out_imag  output  32*DATA_WIDTH each  registered results, same packing

## Operation
- Reset (reset=0), applied asynchronously:
  - All output registers and input-capture registers go to 0.
  - Butterfly counter goes to 0; state goes to IDLE.
  - stage4_busy=0, stage4_Finish=0.
- FSM states:
  - IDLE:
    - If stage4_start is sampled high, capture all 64 input words and the 16 twiddle words into internal registers.
    - Set counter b=0 and go to RUN.
  - RUN:
    - Issue butterfly b each cycle, then increment b.
    - After issuing b=15, go to DRAIN.
  - DRAIN:
    - Perform the final writeback.
    - Pulse stage4_Finish and return to IDLE.
- Butterfly b (0..15) indexing:
  - g = b[3], k = b[2:0].
  - top = 16g+k, bot = top+8, twiddle slot k.
- Pipeline stage 1 (issue):
  - t_re = A… specifically t_re = B_re*W_re − B_im*W_im and t_im = B_re*W_im + B_im*W_re, where B = captured[bot] and W = twiddle slot k.
  - Compute at 2*DATA_WIDTH+1 bits.
  - Arithmetic-shift right by FRACTION, i.e. truncate toward −∞.
  - Keep the low DATA_WIDTH bits (two's-complement wrap).
  - Register t together with A = captured[top] and the indices top/bot.
- Pipeline stage 2 (writeback):
  - out[top] = A + t and out[bot] = A − t, each wrapped to DATA_WIDTH bits with no saturation.
- Output bank behaviour:
  - Outputs change only at writeback.
  - Between runs, outputs hold the last results.
  - During a run, outputs are a mix of old and new values; they are valid only once stage4_Finish is seen.
- stage4_start handling:
  - Ignored whenever stage4_busy=1.
  - Accepted in the cycle stage4_Finish is high, because the FSM is already IDLE then.
- Input handling:
  - Inputs need only be stable at the start-sampling edge.
  - They may change freely afterwards.

## Timing
- E0 = the edge that samples stage4_start=1 in IDLE. After E0:
  - stage4_busy=1.
- Issue and writeback edges:
  - Butterflies issue at edges E1..E16.
  - Writebacks occur at edges E2..E17.
  - Butterfly b's results are visible after edge E(b+2).
- After E17:
  - stage4_Finish=1 for exactly one cycle.
  - stage4_busy=0.
  - All 32 outputs are final.
- Throughput: one transform per 18 cycles when start is re-pulsed in the finish cycle.
- Reset asserted mid-run:
  - Outputs are zeroed immediately.
  - No Finish pulse is produced for the aborted run.
  - A fresh start after reset release behaves exactly like a first run.

## Test plan
- **Reset:** hold reset=0, then release.
  - All outputs 0x00, stage4_busy=0, stage4_Finish=0.
  - With no start, all values stay 0 for 50 cycles.
- **Identity twiddles:** all twiddles (0x10, 0x00); in0=(0x10,0), in8=(0x20,0), all others 0; pulse start.
  - Finish occurs exactly 17 cycles after E0.
  - out0=(0x30,0x00), out8=(0xF0,0x00), all others 0.
- **−j twiddle:** slot 4 = (0x00, 0xF0); in12=(0x10,0x00), in4=0.
  - out4=(0x00,0xF0), out12=(0x00,0x10).
- **Overflow wrap:** slot 0 = (0x10, 0x00); in16=(0x70,0), in24=(0x20,0).
  - out16=(0x90,0x00), i.e. it wraps with no saturation.
  - out24=(0x50,0x00).
- **Start handling:** re-pulse start at E5.
  - That pulse is ignored; Finish still follows E0 by 17 cycles.
  - A start pulse in the Finish cycle, using new data, yields a second Finish 17 cycles later with the new results.
- **Reset mid-run:** assert reset for 1 cycle at E8.
  - Outputs go to 0 with no Finish pulse.
  - A subsequent start on the identity-twiddle data reproduces the expected identity-twiddle results.

Source files
------------

// File: rtl/fft_stage4_seq.sv
// Fourth radix-2 DIT stage of the 32-point FFT: 16 span-8 butterflies issued serially
// through one shared complex butterfly (issue + writeback pipeline) into a registered bank.
module fft_stage4_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int INTEGER    = 4,
   parameter int FRACTION   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stage4_start,
   output logic                     stage4_Finish,
   output logic                     stage4_busy,
   input  logic [32*DATA_WIDTH-1:0] Stage3_out_real,
   input  logic [32*DATA_WIDTH-1:0] Stage3_out_imag,
   input  logic [8*DATA_WIDTH-1:0]  Twiddle_real,
   input  logic [8*DATA_WIDTH-1:0]  Twiddle_imag,
   output logic [32*DATA_WIDTH-1:0] Stage4_out_real,
   output logic [32*DATA_WIDTH-1:0] Stage4_out_imag
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = 2*DATA_WIDTH + 1;

   if (INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_format
      $error("INTEGER + FRACTION must equal DATA_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state;
   logic [3:0]            b;
   logic signed [DW-1:0]  cap_re [32];
   logic signed [DW-1:0]  cap_im [32];
   logic signed [DW-1:0]  tw_re  [8];
   logic signed [DW-1:0]  tw_im  [8];
   logic signed [DW-1:0]  out_re [32];
   logic signed [DW-1:0]  out_im [32];

   logic                  p_vld;
   logic [4:0]            p_top, p_bot;
   logic signed [DW-1:0]  p_a_re, p_a_im, p_t_re, p_t_im;

   logic [2:0]            k;
   logic [4:0]            top, bot;
   logic signed [PW-1:0]  br, bi, wr, wi, pr, pi;
   logic signed [DW-1:0]  t_re, t_im;

   assign k   = b[2:0];
   assign top = {b[3], 1'b0, k};
   assign bot = {b[3], 1'b1, k};

   // Operands widened first so the products and sums are exact; the >>> floors,
   // and the final size cast wraps to DW bits.
   always_comb begin
      br   = PW'(cap_re[bot]);
      bi   = PW'(cap_im[bot]);
      wr   = PW'(tw_re[k]);
      wi   = PW'(tw_im[k]);
      pr   = br*wr - bi*wi;
      pi   = br*wi + bi*wr;
      t_re = DW'(pr >>> FRACTION);
      t_im = DW'(pi >>> FRACTION);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         b             <= '0;
         stage4_busy   <= 1'b0;
         stage4_Finish <= 1'b0;
         p_vld         <= 1'b0;
         p_top         <= '0;
         p_bot         <= '0;
         p_a_re        <= '0;
         p_a_im        <= '0;
         p_t_re        <= '0;
         p_t_im        <= '0;
         for (int unsigned i = 0; i < 32; i++) begin
            cap_re[i] <= '0;
            cap_im[i] <= '0;
            out_re[i] <= '0;
            out_im[i] <= '0;
         end
         for (int unsigned i = 0; i < 8; i++) begin
            tw_re[i] <= '0;
            tw_im[i] <= '0;
         end
      end else begin
         stage4_Finish <= 1'b0;
         p_vld         <= 1'b0;

         if (p_vld) begin
            out_re[p_top] <= p_a_re + p_t_re;
            out_im[p_top] <= p_a_im + p_t_im;
            out_re[p_bot] <= p_a_re - p_t_re;
            out_im[p_bot] <= p_a_im - p_t_im;
         end

         case (state)
            IDLE: begin
               if (stage4_start) begin
                  for (int unsigned i = 0; i < 32; i++) begin
                     cap_re[i] <= Stage3_out_real[i*DW +: DW];
                     cap_im[i] <= Stage3_out_imag[i*DW +: DW];
                  end
                  for (int unsigned i = 0; i < 8; i++) begin
                     tw_re[i] <= Twiddle_real[i*DW +: DW];
                     tw_im[i] <= Twiddle_imag[i*DW +: DW];
                  end
                  b           <= '0;
                  stage4_busy <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               p_vld  <= 1'b1;
               p_top  <= top;
               p_bot  <= bot;
               p_a_re <= cap_re[top];
               p_a_im <= cap_im[top];
               p_t_re <= t_re;
               p_t_im <= t_im;
               b      <= b + 4'd1;
               if (b == 4'd15) state <= DRAIN;
            end
            DRAIN: begin
               stage4_busy   <= 1'b0;
               stage4_Finish <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar n = 0; n < 32; n++) begin : g_pack
      assign Stage4_out_real[n*DW +: DW] = out_re[n];
      assign Stage4_out_imag[n*DW +: DW] = out_im[n];
   end

endmodule
